bus_cycle_sequencer: RTL and testbench

Parametrised 8288-class bus controller for the PC/XT core. It tracks the 8088 status lines S2..S0 through an explicit T1/T2/T3/TW/T4 bus-cycle state machine and inserts programmable per-space wait states plus READY-driven wait states. It generates the I/O, memory and interrupt-acknowledge command strobes and the ALE, DT/R#, DEN and MCE controls. It sits between the CPU status outputs and the system bus, in place of the fixed-timing controller.

---
 rtl/bus_cycle_sequencer_if.sv | 44 ++++
 rtl/bus_cycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_sequencer_if.sv
// rtl/bus_cycle_sequencer_if.sv - CPU status / system command bus bundle for the bus cycle sequencer
interface bus_cycle_sequencer_if;
    logic [2:0] processor_status;
    logic       ready;
    logic       command_enable;
    logic       address_enable_n;
    logic       io_bus_mode;

    logic       io_read_command_n;
    logic       io_write_command_n;
    logic       advanced_io_write_command_n;
    logic       interrupt_acknowledge_n;
    logic       memory_read_command_n;
    logic       memory_write_command_n;
    logic       advanced_memory_write_command_n;
    logic       enable_io_command;
    logic       enable_memory_command;
    logic       address_latch_enable;
    logic       direction_transmit_or_receive_n;
    logic       data_enable;
    logic       peripheral_data_enable_n;
    logic       master_cascade_enable;
    logic       wait_state_active;
    logic       bus_busy;

    // The sequencer side drives the command bus.
    modport master (
        input  processor_status, ready, command_enable, address_enable_n, io_bus_mode,
        output io_read_command_n, io_write_command_n, advanced_io_write_command_n,
               interrupt_acknowledge_n, memory_read_command_n, memory_write_command_n,
               advanced_memory_write_command_n, enable_io_command, enable_memory_command,
               address_latch_enable, direction_transmit_or_receive_n, data_enable,
               peripheral_data_enable_n, master_cascade_enable, wait_state_active, bus_busy
    );

    modport slave (
        output processor_status, ready, command_enable, address_enable_n, io_bus_mode,
        input  io_read_command_n, io_write_command_n, advanced_io_write_command_n,
               interrupt_acknowledge_n, memory_read_command_n, memory_write_command_n,
               advanced_memory_write_command_n, enable_io_command, enable_memory_command,
               address_latch_enable, direction_transmit_or_receive_n, data_enable,
               peripheral_data_enable_n, master_cascade_enable, wait_state_active, bus_busy
    );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// rtl/bus_cycle_sequencer.sv - 8288-class bus controller with T1..T4/TW sequencing and wait-state insertion
// Optional BUS_CYCLE_READY_SYNC_EN: pass READY through a two-flop synchronizer before use.
module bus_cycle_sequencer #(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned WS_WIDTH        = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_clock,
    bus_cycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TW   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    localparam logic [2:0] ST_INTA    = 3'b000;
    localparam logic [2:0] ST_IO_RD   = 3'b001;
    localparam logic [2:0] ST_IO_WR   = 3'b010;
    localparam logic [2:0] ST_HALT    = 3'b011;
    localparam logic [2:0] ST_FETCH   = 3'b100;
    localparam logic [2:0] ST_MEM_RD  = 3'b101;
    localparam logic [2:0] ST_MEM_WR  = 3'b110;
    localparam logic [2:0] ST_PASSIVE = 3'b111;

    state_t              state;
    logic [WS_WIDTH-1:0] ws_cnt;
    logic [2:0]          latched_status;
    logic                cpu_clock_s;
    logic                cpu_clock_d;
    logic                wait_state_q;
    logic                busy_q;
    logic                tick;
    logic                ready_s;

`ifdef BUS_CYCLE_READY_SYNC_EN
    logic ready_meta;
    logic ready_sync;
    assign ready_s = ready_sync;
`else
    assign ready_s = bus.ready;
`endif

    // cpu_clock is registered before edge detection, so a tick lands one clock after the edge is seen.
    assign tick = cpu_clock_s & ~cpu_clock_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ws_cnt         <= '0;
            latched_status <= ST_PASSIVE;
            cpu_clock_s    <= 1'b0;
            cpu_clock_d    <= 1'b0;
            wait_state_q   <= 1'b0;
            busy_q         <= 1'b0;
`ifdef BUS_CYCLE_READY_SYNC_EN
            ready_meta     <= 1'b0;
            ready_sync     <= 1'b0;
`endif
        end else begin
            cpu_clock_s <= cpu_clock;
            cpu_clock_d <= cpu_clock_s;
`ifdef BUS_CYCLE_READY_SYNC_EN
            ready_meta  <= bus.ready;
            ready_sync  <= ready_meta;
`endif
            if (tick) begin
                case (state)
                    S_IDLE, S_T4: begin
                        wait_state_q <= 1'b0;
                        if (bus.processor_status != ST_PASSIVE) begin
                            latched_status <= bus.processor_status;
                            state          <= S_T1;
                            busy_q         <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    S_T1: begin
                        wait_state_q <= 1'b0;
                        if (latched_status == ST_HALT) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= S_T2;
                            busy_q <= 1'b1;
                            ws_cnt <= latched_status[2] ? WS_WIDTH'(MEM_WAIT_STATES)
                                                        : WS_WIDTH'(IO_WAIT_STATES);
                        end
                    end
                    S_T2: begin
                        state        <= S_T3;
                        busy_q       <= 1'b1;
                        wait_state_q <= 1'b0;
                    end
                    S_T3, S_TW: begin
                        busy_q <= 1'b1;
                        // Programmed waits are served first, then READY can stretch further.
                        if (ws_cnt != '0) begin
                            ws_cnt       <= ws_cnt - 1'b1;
                            state        <= S_TW;
                            wait_state_q <= 1'b1;
                        end else if (!ready_s) begin
                            state        <= S_TW;
                            wait_state_q <= 1'b1;
                        end else begin
                            state        <= S_T4;
                            wait_state_q <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        busy_q       <= 1'b0;
                        wait_state_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic in_cmd_window;
    logic in_write_window;
    logic in_cycle;
    logic st_inta, st_io_rd, st_io_wr, st_halt, st_fetch, st_mem_rd, st_mem_wr;
    logic read_type;
    logic write_type;
    logic den;

    assign in_cmd_window   = (state == S_T2) || (state == S_T3) || (state == S_TW);
    assign in_write_window = (state == S_T3) || (state == S_TW);
    assign in_cycle        = (state != S_IDLE);

    assign st_inta   = (latched_status == ST_INTA);
    assign st_io_rd  = (latched_status == ST_IO_RD);
    assign st_io_wr  = (latched_status == ST_IO_WR);
    assign st_halt   = (latched_status == ST_HALT);
    assign st_fetch  = (latched_status == ST_FETCH);
    assign st_mem_rd = (latched_status == ST_MEM_RD);
    assign st_mem_wr = (latched_status == ST_MEM_WR);

    assign read_type  = st_inta | st_io_rd | st_fetch | st_mem_rd;
    assign write_type = st_io_wr | st_mem_wr;

    assign bus.io_read_command_n               = ~(bus.command_enable & st_io_rd & in_cmd_window);
    assign bus.io_write_command_n              = ~(bus.command_enable & st_io_wr & in_write_window);
    assign bus.advanced_io_write_command_n     = ~(bus.command_enable & st_io_wr & in_cmd_window);
    assign bus.interrupt_acknowledge_n         = ~(bus.command_enable & st_inta & in_cmd_window);
    assign bus.memory_read_command_n           = ~(bus.command_enable & (st_fetch | st_mem_rd) & in_cmd_window);
    assign bus.memory_write_command_n          = ~(bus.command_enable & st_mem_wr & in_write_window);
    assign bus.advanced_memory_write_command_n = ~(bus.command_enable & st_mem_wr & in_cmd_window);

    assign bus.enable_memory_command = ~bus.address_enable_n;
    assign bus.enable_io_command     = ~bus.address_enable_n | bus.io_bus_mode;

    // Writes hold DEN through T4 so data stays driven while the write strobe trails off.
    assign den = bus.command_enable &
                 ((read_type & in_cmd_window) | (write_type & (in_cmd_window | (state == S_T4))));

    assign bus.address_latch_enable            = (state == S_T1) & ~st_halt;
    assign bus.master_cascade_enable           = (state == S_T1) & st_inta;
    assign bus.direction_transmit_or_receive_n = ~(in_cycle & read_type);
    assign bus.data_enable                     = den;
    assign bus.peripheral_data_enable_n        = ~den;
    assign bus.wait_state_active               = wait_state_q;
    assign bus.bus_busy                        = busy_q;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb/tb_bus_cycle_sequencer.sv - scoreboard bench for bus_cycle_sequencer (default build)
module tb_bus_cycle_sequencer;
    localparam int P_IDLE = 0;
    localparam int P_T1   = 1;
    localparam int P_T2   = 2;
    localparam int P_T3   = 3;
    localparam int P_TW   = 4;
    localparam int P_T4   = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_clock = 1'b0;

    bus_cycle_sequencer_if bus();

    bus_cycle_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_clock (cpu_clock),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb[$];

    // Expected output vector for a bus phase with a given latched status.
    function automatic logic [15:0] exp_vec(input int ph, input logic [2:0] st,
                                            input logic ce, input logic aen_n, input logic iobm);
        logic cmd, wr, is_read, is_write;
        logic iord, iowr, aiow, inta, mrd, mwr, amw, ale, dtr_n, den, mce, wsa, busy;
        cmd      = (ph == P_T2) || (ph == P_T3) || (ph == P_TW);
        wr       = (ph == P_T3) || (ph == P_TW);
        is_read  = (st == 3'd0) || (st == 3'd1) || (st == 3'd4) || (st == 3'd5);
        is_write = (st == 3'd2) || (st == 3'd6);
        iord  = ce && cmd && st == 3'd1;
        aiow  = ce && cmd && st == 3'd2;
        iowr  = ce && wr  && st == 3'd2;
        inta  = ce && cmd && st == 3'd0;
        mrd   = ce && cmd && (st == 3'd4 || st == 3'd5);
        amw   = ce && cmd && st == 3'd6;
        mwr   = ce && wr  && st == 3'd6;
        ale   = (ph == P_T1) && st != 3'd3;
        mce   = (ph == P_T1) && st == 3'd0;
        dtr_n = !((ph != P_IDLE) && is_read);
        den   = ce && ((is_read && cmd) || (is_write && (cmd || ph == P_T4)));
        wsa   = (ph == P_TW);
        busy  = (ph != P_IDLE);
        return {~iord, ~iowr, ~aiow, ~inta, ~mrd, ~mwr, ~amw, ~aen_n | iobm, ~aen_n,
                ale, dtr_n, den, ~den, mce, wsa, busy};
    endfunction

    function automatic logic [15:0] observe();
        return {bus.io_read_command_n, bus.io_write_command_n, bus.advanced_io_write_command_n,
                bus.interrupt_acknowledge_n, bus.memory_read_command_n, bus.memory_write_command_n,
                bus.advanced_memory_write_command_n, bus.enable_io_command, bus.enable_memory_command,
                bus.address_latch_enable, bus.direction_transmit_or_receive_n, bus.data_enable,
                bus.peripheral_data_enable_n, bus.master_cascade_enable, bus.wait_state_active,
                bus.bus_busy};
    endfunction

    // One full cpu_clock period; afterwards the DUT has taken exactly one tick and settled.
    task automatic do_tick();
        @(negedge clock) cpu_clock = 1'b1;
        repeat (3) @(negedge clock);
        cpu_clock = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic drive_tick(input logic [2:0] status, input logic rdy, input int ph, input logic [2:0] st);
        bus.processor_status = status;
        bus.ready = rdy;
        sb.push_back(exp_vec(ph, st, bus.command_enable, bus.address_enable_n, bus.io_bus_mode));
        do_tick();
    endtask

    task automatic test_reset();
        logic [15:0] obs, exp;
        repeat (3) @(negedge clock);
        sb.push_back(exp_vec(P_IDLE, 3'b111, bus.command_enable, 1'b0, 1'b0));
        obs = observe(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, exp); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        sb.push_back(exp_vec(P_IDLE, 3'b111, bus.command_enable, 1'b0, 1'b0));
        obs = observe(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_released: got %h expected %h", obs, exp); end
    endtask

    task automatic test_enables();
        logic [15:0] obs, exp;
        for (int k = 0; k < 4; k++) begin
            bus.address_enable_n = k[0];
            bus.io_bus_mode = k[1];
            #1;
            sb.push_back(exp_vec(P_IDLE, 3'b111, 1'b1, k[0], k[1]));
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL enables combo %0d: got %h expected %h", k, obs, exp); end
        end
        bus.address_enable_n = 1'b0;
        bus.io_bus_mode = 1'b0;
        #1;
    endtask

    task automatic test_memory_read();
        int ph[5] = '{P_T1, P_T2, P_T3, P_T4, P_IDLE};
        logic [15:0] obs, exp;
        int lows = 0;
        for (int i = 0; i < 5; i++) begin
            drive_tick(i == 0 ? 3'b101 : 3'b111, 1'b1, ph[i], 3'b101);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (!bus.memory_read_command_n) lows++;
            if (obs !== exp) begin n_fail++; $display("FAIL memory_read tick %0d: got %h expected %h", i, obs, exp); end
        end
        n_checks++;
        if (lows !== 2) begin n_fail++; $display("FAIL memory_read_strobe_ticks: got %0d expected 2", lows); end
    endtask

    task automatic test_io_write();
        int ph[6] = '{P_T1, P_T2, P_T3, P_TW, P_T4, P_IDLE};
        logic [15:0] obs, exp;
        int waits = 0;
        for (int i = 0; i < 6; i++) begin
            drive_tick(i == 0 ? 3'b010 : 3'b111, 1'b1, ph[i], 3'b010);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (bus.wait_state_active) waits++;
            if (obs !== exp) begin n_fail++; $display("FAIL io_write tick %0d: got %h expected %h", i, obs, exp); end
        end
        n_checks++;
        if (waits !== 1) begin n_fail++; $display("FAIL io_write_wait_ticks: got %0d expected 1", waits); end
    endtask

    task automatic test_ready_wait();
        int ph[8] = '{P_T1, P_T2, P_T3, P_TW, P_TW, P_TW, P_T4, P_IDLE};
        logic rdy[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] obs, exp;
        int waits = 0;
        for (int i = 0; i < 8; i++) begin
            drive_tick(i == 0 ? 3'b110 : 3'b111, rdy[i], ph[i], 3'b110);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (bus.wait_state_active) waits++;
            if (obs !== exp) begin n_fail++; $display("FAIL ready_wait tick %0d: got %h expected %h", i, obs, exp); end
        end
        n_checks++;
        if (waits !== 3) begin n_fail++; $display("FAIL ready_wait_ticks: got %0d expected 3", waits); end
    endtask

    task automatic test_inta();
        int ph[6] = '{P_T1, P_T2, P_T3, P_TW, P_T4, P_IDLE};
        logic [15:0] obs, exp;
        for (int pass = 0; pass < 2; pass++) begin
            bus.command_enable = (pass == 0);
            for (int i = 0; i < 6; i++) begin
                drive_tick(i == 0 ? 3'b000 : 3'b111, 1'b1, ph[i], 3'b000);
                obs = observe(); exp = sb.pop_front(); n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL inta ce=%0d tick %0d: got %h expected %h", bus.command_enable, i, obs, exp);
                end
            end
        end
        bus.command_enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ph[9] = '{P_T1, P_T2, P_T3, P_T4, P_T1, P_T2, P_T3, P_T4, P_IDLE};
        logic [15:0] obs, exp;
        for (int i = 0; i < 9; i++) begin
            drive_tick((i == 0 || i == 4) ? 3'b100 : 3'b111, 1'b1, ph[i], 3'b100);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL back_to_back tick %0d: got %h expected %h", i, obs, exp); end
        end
    endtask

    task automatic test_halt();
        int ph[2] = '{P_T1, P_IDLE};
        logic [15:0] obs, exp;
        for (int i = 0; i < 2; i++) begin
            drive_tick(i == 0 ? 3'b011 : 3'b111, 1'b1, ph[i], 3'b011);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL halt tick %0d: got %h expected %h", i, obs, exp); end
        end
    endtask

    task automatic test_reset_mid_cycle();
        int ph_a[4] = '{P_T1, P_T2, P_T3, P_TW};
        int ph_b[6] = '{P_T1, P_T2, P_T3, P_TW, P_T4, P_IDLE};
        logic [15:0] obs, exp;
        for (int i = 0; i < 4; i++) begin
            drive_tick(i == 0 ? 3'b010 : 3'b111, 1'b1, ph_a[i], 3'b010);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL pre_reset tick %0d: got %h expected %h", i, obs, exp); end
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        sb.push_back(exp_vec(P_IDLE, 3'b111, 1'b1, 1'b0, 1'b0));
        obs = observe(); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL async_reset_in_tw: got %h expected %h", obs, exp); end
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_tick(i == 0 ? 3'b001 : 3'b111, 1'b1, ph_b[i], 3'b001);
            obs = observe(); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL post_reset tick %0d: got %h expected %h", i, obs, exp); end
        end
    endtask

    initial begin
        bus.processor_status = 3'b111;
        bus.ready            = 1'b1;
        bus.command_enable   = 1'b1;
        bus.address_enable_n = 1'b0;
        bus.io_bus_mode      = 1'b0;
        test_reset();
        test_enables();
        test_memory_read();
        test_io_write();
        test_ready_wait();
        test_inta();
        test_back_to_back();
        test_halt();
        test_reset_mid_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
